// File: rtl/fp_multiplication.sv
// IEEE-754 binary32 multiplier, round-to-nearest-even, DAZ/FTZ.
// Two register stages: operand classify + 24x24 product, then normalize/round/pack.
module fp_multiplication (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    localparam logic [1:0] CLS_NUM  = 2'd0;
    localparam logic [1:0] CLS_ZERO = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NAN  = 2'd3;

    logic [7:0]         a_exp, b_exp;
    logic [22:0]        a_frac, b_frac;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    logic               sign_d, sign_q;
    logic [1:0]         cls_d, cls_q;
    logic signed [9:0]  exp_d, exp_q;
    logic [47:0]        prod_d, prod_q;
    logic [31:0]        result_d, result_q;

    // Stage 1: classify operands, form product and biased exponent sum
    always_comb begin
        a_exp  = a[30:23];
        b_exp  = b[30:23];
        a_frac = a[22:0];
        b_frac = b[22:0];
        // exp==0 covers subnormals too: they are flushed to zero on input
        a_zero = (a_exp == 8'h00);
        b_zero = (b_exp == 8'h00);
        a_inf  = (a_exp == 8'hFF) && (a_frac == 23'h0);
        b_inf  = (b_exp == 8'hFF) && (b_frac == 23'h0);
        a_nan  = (a_exp == 8'hFF) && (a_frac != 23'h0);
        b_nan  = (b_exp == 8'hFF) && (b_frac != 23'h0);

        sign_d = a[31] ^ b[31];
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
            cls_d = CLS_NAN;
        else if (a_inf || b_inf)
            cls_d = CLS_INF;
        else if (a_zero || b_zero)
            cls_d = CLS_ZERO;
        else
            cls_d = CLS_NUM;

        prod_d = 48'({1'b1, a_frac}) * 48'({1'b1, b_frac});
        exp_d  = $signed({2'b00, a_exp} + {2'b00, b_exp} - 10'd127);
    end

    logic [22:0]        mant;
    logic               guard, sticky, rnd_inc;
    logic [23:0]        mant_r;
    logic signed [9:0]  exp_n, exp_r;

    // Stage 2: normalize by one position at most, round, then saturate/flush
    always_comb begin
        if (prod_q[47]) begin
            mant   = prod_q[46:24];
            guard  = prod_q[23];
            sticky = |prod_q[22:0];
            exp_n  = exp_q + 10'sd1;
        end else begin
            mant   = prod_q[45:23];
            guard  = prod_q[22];
            sticky = |prod_q[21:0];
            exp_n  = exp_q;
        end
        rnd_inc = guard & (sticky | mant[0]);
        mant_r  = {1'b0, mant} + {23'h0, rnd_inc};
        // a carry out leaves the low 23 bits at zero, which is the correct fraction
        exp_r   = exp_n + $signed({9'h0, mant_r[23]});

        case (cls_q)
            CLS_NAN:  result_d = 32'h7FC0_0000;
            CLS_INF:  result_d = {sign_q, 8'hFF, 23'h0};
            CLS_ZERO: result_d = {sign_q, 31'h0};
            default: begin
                if (exp_r >= 10'sd255)
                    result_d = {sign_q, 8'hFF, 23'h0};
                else if (exp_r <= 10'sd0)
                    result_d = {sign_q, 31'h0};
                else
                    result_d = {sign_q, exp_r[7:0], mant_r[22:0]};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q   <= 1'b0;
            cls_q    <= CLS_NUM;
            exp_q    <= '0;
            prod_q   <= '0;
            result_q <= '0;
        end else begin
            sign_q   <= sign_d;
            cls_q    <= cls_d;
            exp_q    <= exp_d;
            prod_q   <= prod_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_fp_multiplication.sv
// Self-checking bench for fp_multiplication: directed vectors, specials,
// randomized back-to-back stream against an integer-arithmetic reference, resets.
module tb_fp_multiplication;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    fp_multiplication dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .result (result)
    );

    always #5 clk = ~clk;

    // Reference: exact integer product, then RNE via remainder vs half-ulp.
    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic        s;
        int          ex, ey, e, sh;
        logic        xz, yz, xi, yi, xn, yn;
        longint      p, q, rem, half;
        logic [63:0] qb;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == 255) && (x[22:0] == 0);
        yi = (ey == 255) && (y[22:0] == 0);
        xn = (ex == 255) && (x[22:0] != 0);
        yn = (ey == 255) && (y[22:0] != 0);
        if (xn || yn) return 32'h7FC0_0000;
        if ((xi && yz) || (xz && yi)) return 32'h7FC0_0000;
        if (xi || yi) return {s, 8'hFF, 23'h0};
        if (xz || yz) return {s, 31'h0};
        p = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
        e = ex + ey - 127;
        if (p >= (64'sd1 <<< 47)) begin
            sh = 24;
            e  = e + 1;
        end else begin
            sh = 23;
        end
        q    = p >>> sh;
        rem  = p - (q <<< sh);
        half = 64'sd1 <<< (sh - 1);
        if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
        if (q == (64'sd1 <<< 24)) begin
            q = q >>> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        qb = 64'(q);
        return {s, 8'(e), qb[22:0]};
    endfunction

    function automatic logic [31:0] rand_operand();
        int          k;
        logic [31:0] v;
        k = $urandom_range(0, 15);
        v = $urandom;
        case (k)
            0: v[30:23] = 8'h00;
            1: begin v[30:23] = 8'hFF; v[22:0] = 23'h0; end
            2: v[30:23] = 8'hFF;
            3: v[22:0] = 23'h7FFFFF;
            default: v[30:23] = 8'($urandom_range(1, 254));
        endcase
        return v;
    endfunction

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (result !== 32'h0) begin
            failures++;
            $display("FAIL reset_async result=%h expected=%h", result, 32'h0);
        end
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (result !== 32'h0) begin
            failures++;
            $display("FAIL reset_hold result=%h expected=%h", result, 32'h0);
        end
        rst_n = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (result !== 32'h0) begin
            failures++;
            $display("FAIL reset_idle result=%h expected=%h", result, 32'h0);
        end
    endtask

    task automatic test_latency();
        a = 32'h3FC0_0000;
        b = 32'h3FA0_0000;
        @(posedge clk); #1;
        a = 32'h0;
        b = 32'h0;
        checks++;
        if (result !== 32'h0) begin
            failures++;
            $display("FAIL latency_early result=%h expected=%h", result, 32'h0);
        end
        @(posedge clk); #1;
        checks++;
        if (result !== 32'h3FF0_0000) begin
            failures++;
            $display("FAIL latency_2clk result=%h expected=%h", result, 32'h3FF0_0000);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va[14], vb[14], vr[14];
        logic [31:0] exq[$];
        logic [31:0] ex;
        va = '{32'h3FC00000, 32'h42540000, 32'hBFE00000, 32'hC1200000, 32'h7F800000,
               32'h7F000000, 32'h80000000, 32'h3F800001, 32'h3FFFFFFF, 32'h00800000,
               32'h80800000, 32'h00000001, 32'h7FC00001, 32'hFF800000};
        vb = '{32'h3FA00000, 32'h42CC0000, 32'h42C80000, 32'hC1A40000, 32'h00000000,
               32'h40000000, 32'h3F800000, 32'h3F800001, 32'h3FFFFFFF, 32'h00800000,
               32'h00800000, 32'h3F800000, 32'h00000000, 32'h40000000};
        vr = '{32'h3FF00000, 32'h45A8F000, 32'hC32F0000, 32'h434D0000, 32'h7FC00000,
               32'h7F800000, 32'h80000000, 32'h3F800002, 32'h407FFFFE, 32'h00000000,
               32'h80000000, 32'h00000000, 32'h7FC00000, 32'hFF800000};
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (i >= 2) begin
                ex = exq.pop_front();
                checks++;
                if (result !== ex) begin
                    failures++;
                    $display("FAIL directed[%0d] %h*%h result=%h expected=%h",
                             i - 2, va[i-2], vb[i-2], result, ex);
                end
            end
            if (i < 14) begin
                a = va[i];
                b = vb[i];
                exq.push_back(vr[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exq[$];
        logic [31:0] aq[$], bq[$];
        logic [31:0] ex, xa, xb;
        int          n;
        n = 400;
        for (int i = 0; i < n + 2; i++) begin
            @(posedge clk); #1;
            if (i >= 2) begin
                ex = exq.pop_front();
                xa = aq.pop_front();
                xb = bq.pop_front();
                checks++;
                if (result !== ex) begin
                    failures++;
                    $display("FAIL random %h*%h result=%h expected=%h", xa, xb, result, ex);
                end
            end
            if (i < n) begin
                a = rand_operand();
                b = rand_operand();
                aq.push_back(a);
                bq.push_back(b);
                exq.push_back(ref_mul(a, b));
            end
        end
    endtask

    task automatic test_mid_reset();
        a = 32'hC1200000;
        b = 32'hC1A40000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (result !== 32'h434D0000) begin
            failures++;
            $display("FAIL midrst_pre result=%h expected=%h", result, 32'h434D0000);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (result !== 32'h0) begin
            failures++;
            $display("FAIL midrst_async result=%h expected=%h", result, 32'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        a = 32'h42540000;
        b = 32'h42CC0000;
        @(posedge clk); #1;
        checks++;
        if (result !== 32'h0) begin
            failures++;
            $display("FAIL midrst_flushed result=%h expected=%h", result, 32'h0);
        end
        @(posedge clk); #1;
        checks++;
        if (result !== 32'h45A8F000) begin
            failures++;
            $display("FAIL midrst_first result=%h expected=%h", result, 32'h45A8F000);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
